// File: rtl/udma_uart_tx_sched.sv
// Byte scheduler feeding the UART serializer: arbitrates NUM_REQ requesters, applies CTS and guard gap.
// States: IDLE arbitrate/grant | SEND offer byte | START await busy | DRAIN await idle | GUARD gap count
module udma_uart_tx_sched #(
    parameter int NUM_REQ = 4,
    parameter int GUARD_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       cfg_en_i,
    input  logic                       cfg_prio_i,
    input  logic                       cfg_cts_en_i,
    input  logic [GUARD_W-1:0]         cfg_guard_i,
    input  logic                       cts_ni,
    input  logic [NUM_REQ*8-1:0]       req_data_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [7:0]                 tx_data_o,
    output logic                       tx_valid_o,
    input  logic                       tx_ready_i,
    input  logic                       tx_busy_i,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       active_o
);

    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEND  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_GUARD = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [7:0]         hold_q, hold_d;
    logic [GUARD_W-1:0] guard_cnt_q, guard_cnt_d;
    logic               cts_meta_q, cts_sync_q;

    logic               cts_ok, eligible, prio_win, found;
    logic [ID_W-1:0]    winner, rr_next;
    logic [ID_W:0]      idx;

    assign cts_ok   = !cfg_cts_en_i || !cts_sync_q;
    assign eligible = cfg_en_i && cts_ok && (|req_valid_i);
    assign prio_win = cfg_prio_i && req_valid_i[0];

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        if (!prio_win) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
                if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
                if (!found && req_valid_i[idx[ID_W-1:0]]) begin
                    winner = idx[ID_W-1:0];
                    found  = 1'b1;
                end
            end
        end
    end

    assign rr_next = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + ID_W'(1);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        hold_d      = hold_q;
        guard_cnt_d = guard_cnt_q;
        req_ready_o = '0;
        tx_valid_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (eligible) begin
                    req_ready_o = NUM_REQ'(1) << winner;
                    hold_d      = req_data_i[{winner, 3'b000} +: 8];
                    grant_d     = winner;
                    if (!prio_win) rr_ptr_d = rr_next;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_valid_o = cts_ok;
                if (cts_ok && tx_ready_i) state_d = ST_START;
            end
            ST_START: begin
                if (tx_busy_i)      state_d = ST_DRAIN;
                else if (!cfg_en_i) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (!tx_busy_i) begin
                    if (cfg_guard_i != '0) begin
                        guard_cnt_d = cfg_guard_i;
                        state_d     = ST_GUARD;
                    end else begin
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_GUARD: begin
                guard_cnt_d = guard_cnt_q - GUARD_W'(1);
                if (guard_cnt_q == GUARD_W'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            hold_q      <= 8'h00;
            guard_cnt_q <= '0;
            cts_meta_q  <= 1'b1;
            cts_sync_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            hold_q      <= hold_d;
            guard_cnt_q <= guard_cnt_d;
            cts_meta_q  <= cts_ni;
            cts_sync_q  <= cts_meta_q;
        end
    end

    assign tx_data_o  = hold_q;
    assign grant_id_o = grant_q;
    assign active_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_udma_uart_tx_sched.sv
// Directed bench for udma_uart_tx_sched with a simple transmitter model (busy 10 cycles, one cycle after accept).
`timescale 1ns/1ps
module tb_udma_uart_tx_sched;
    localparam int NUM_REQ  = 4;
    localparam int GUARD_W  = 8;
    localparam int ID_W     = 2;
    localparam int BUSY_LEN = 10;

    logic                 clk_i = 1'b0;
    logic                 rstn_i;
    logic                 cfg_en_i, cfg_prio_i, cfg_cts_en_i;
    logic [GUARD_W-1:0]   cfg_guard_i;
    logic                 cts_ni;
    logic [NUM_REQ*8-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [7:0]           tx_data_o;
    logic                 tx_valid_o, tx_ready_i, tx_busy_i;
    logic [ID_W-1:0]      grant_id_o;
    logic                 active_o;

    int checks = 0;
    int errors = 0;
    bit model_ready = 1'b1;
    bit start_pending;
    int busy_cnt;

    udma_uart_tx_sched #(.NUM_REQ(NUM_REQ), .GUARD_W(GUARD_W)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .cfg_en_i(cfg_en_i), .cfg_prio_i(cfg_prio_i),
        .cfg_cts_en_i(cfg_cts_en_i), .cfg_guard_i(cfg_guard_i), .cts_ni(cts_ni),
        .req_data_i(req_data_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .tx_busy_i(tx_busy_i), .grant_id_o(grant_id_o), .active_o(active_o)
    );

    always #5 clk_i = ~clk_i;

    // Transmitter: accepts on valid&ready, raises busy the next cycle for BUSY_LEN cycles.
    initial begin
        tx_busy_i     = 1'b0;
        tx_ready_i    = 1'b0;
        start_pending = 1'b0;
        busy_cnt      = 0;
        forever begin
            @(negedge clk_i);
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy_i = 1'b0;
            end
            if (start_pending) begin
                tx_busy_i     = 1'b1;
                busy_cnt      = BUSY_LEN;
                start_pending = 1'b0;
            end
            tx_ready_i = model_ready && !tx_busy_i;
            if (tx_valid_o && tx_ready_i) start_pending = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rstn_i      = 1'b0;
        req_valid_i = '0;
        repeat (BUSY_LEN + 3) tick();
        rstn_i = 1'b1;
        tick();
    endtask

    task automatic wait_grant(input int max_cyc, output int idx, output int waited);
        waited = 0;
        idx    = -1;
        #1;
        while (req_ready_o === '0 && waited < max_cyc) begin
            tick();
            waited++;
        end
        if ($onehot(req_ready_o)) begin
            for (int k = 0; k < NUM_REQ; k++) if (req_ready_o[k]) idx = k;
        end else if (req_ready_o !== '0) begin
            idx = -2;
        end
    endtask

    task automatic wait_busy_fall(input int max_cyc, output bit ok);
        int n;
        n = 0;
        while (tx_busy_i !== 1'b1 && n < max_cyc) begin tick(); n++; end
        while (tx_busy_i !== 1'b0 && n < max_cyc) begin tick(); n++; end
        ok = (n < max_cyc) && (tx_busy_i === 1'b0);
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        int n;
        n = 0;
        while (active_o !== 1'b0 && n < max_cyc) begin tick(); n++; end
        ok = (active_o === 1'b0);
    endtask

    task automatic test_reset();
        int bad;
        repeat (3) tick();
        checks++;
        if (req_ready_o !== '0 || tx_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_hs: got ready=%b valid=%b expected 0000/0", req_ready_o, tx_valid_o);
        end
        checks++;
        if (tx_data_o !== 8'h00 || grant_id_o !== 2'd0 || active_o !== 1'b0) begin
            errors++; $display("FAIL reset_out: got data=%h grant=%0d active=%b expected 00/0/0", tx_data_o, grant_id_o, active_o);
        end
        rstn_i = 1'b1;
        tick();
        cfg_en_i    = 1'b0;
        req_valid_i = 4'b0001;
        bad = 0;
        repeat (3) begin
            #1;
            if (req_ready_o !== '0 || active_o !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL disabled_grant: got %0d granting cycles expected 0", bad);
        end
        req_valid_i = '0;
        cfg_en_i    = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        cfg_guard_i = '0;
        req_data_i  = '0;
        req_data_i[23:16] = 8'hA5;
        req_valid_i = 4'b0100;
        #1;
        checks++;
        if (req_ready_o !== 4'b0100) begin
            errors++; $display("FAIL single_ready: got %b expected 0100", req_ready_o);
        end
        tick();
        req_valid_i = '0;
        checks++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hA5) begin
            errors++; $display("FAIL single_tx: got valid=%b data=%h expected 1/a5", tx_valid_o, tx_data_o);
        end
        checks++;
        if (grant_id_o !== 2'd2) begin
            errors++; $display("FAIL single_grant_id: got %0d expected 2", grant_id_o);
        end
        checks++;
        if (req_ready_o !== '0) begin
            errors++; $display("FAIL single_ready_pulse: got %b expected 0000", req_ready_o);
        end
        wait_busy_fall(40, ok);
        checks++;
        if (!ok || active_o !== 1'b1) begin
            errors++; $display("FAIL single_drain: got ok=%b active=%b expected 1/1", ok, active_o);
        end
        tick();
        checks++;
        if (active_o !== 1'b0) begin
            errors++; $display("FAIL single_idle: got active=%b expected 0", active_o);
        end
    endtask

    task automatic test_round_robin();
        int exp_order [6] = '{0, 1, 2, 3, 0, 1};
        int idx, w;
        bit ok;
        logic [7:0] exp_b;
        do_reset();
        cfg_prio_i  = 1'b0;
        req_data_i  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid_i = 4'hF;
        for (int i = 0; i < 6; i++) begin
            wait_grant(40, idx, w);
            checks++;
            if (idx != exp_order[i]) begin
                errors++; $display("FAIL rr_winner[%0d]: got %0d expected %0d", i, idx, exp_order[i]);
            end
            tick();
            exp_b = 8'(16 + exp_order[i]);
            checks++;
            if (grant_id_o !== ID_W'(exp_order[i]) || tx_data_o !== exp_b || tx_valid_o !== 1'b1) begin
                errors++; $display("FAIL rr_byte[%0d]: got id=%0d data=%h valid=%b expected %0d/%h/1",
                                   i, grant_id_o, tx_data_o, tx_valid_o, exp_order[i], exp_b);
            end
        end
        req_valid_i = '0;
        wait_idle(60, ok);
    endtask

    task automatic test_priority();
        int exp_order [5] = '{0, 0, 0, 3, 1};
        int idx, w;
        bit ok;
        do_reset();
        req_data_i  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        cfg_prio_i  = 1'b1;
        req_valid_i = 4'b0100;
        wait_grant(5, idx, w);
        checks++;
        if (idx != 2) begin
            errors++; $display("FAIL prio_setup: got %0d expected 2", idx);
        end
        tick();
        req_valid_i = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            wait_grant(40, idx, w);
            checks++;
            if (idx != exp_order[i]) begin
                errors++; $display("FAIL prio_winner[%0d]: got %0d expected %0d", i, idx, exp_order[i]);
            end
            tick();
            if (i == 2) req_valid_i[0] = 1'b0;
        end
        checks++;
        if (tx_data_o !== 8'hB1) begin
            errors++; $display("FAIL prio_last_byte: got %h expected b1", tx_data_o);
        end
        req_valid_i = '0;
        cfg_prio_i  = 1'b0;
        wait_idle(60, ok);
    endtask

    task automatic test_cts();
        int idx, w, bad, n;
        bit ok;
        cts_ni = 1'b1;
        do_reset();
        cfg_cts_en_i = 1'b1;
        req_data_i   = '0;
        req_data_i[15:8] = 8'h5A;
        req_valid_i  = 4'b0010;
        bad = 0;
        repeat (4) begin
            tick();
            if (req_ready_o !== '0 || tx_valid_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL cts_block: got %0d active cycles expected 0", bad);
        end
        cts_ni = 1'b0;
        wait_grant(6, idx, w);
        checks++;
        if (idx != 1 || w < 2 || w > 3) begin
            errors++; $display("FAIL cts_release: got idx=%0d after %0d cycles expected 1 after 2..3", idx, w);
        end
        tick();
        checks++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h5A) begin
            errors++; $display("FAIL cts_tx: got valid=%b data=%h expected 1/5a", tx_valid_o, tx_data_o);
        end
        n = 0;
        while (tx_busy_i !== 1'b1 && n < 10) begin tick(); n++; end
        cts_ni = 1'b1;
        wait_idle(40, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL cts_frame_done: got active=%b expected 0", active_o);
        end
        bad = 0;
        repeat (8) begin
            tick();
            if (req_ready_o !== '0 || active_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL cts_next_blocked: got %0d granting cycles expected 0", bad);
        end
        cts_ni = 1'b0;
        wait_grant(6, idx, w);
        checks++;
        if (idx != 1) begin
            errors++; $display("FAIL cts_regrant: got %0d expected 1", idx);
        end
        tick();
        req_valid_i = '0;
        wait_idle(60, ok);
        cfg_cts_en_i = 1'b0;
    endtask

    task automatic test_guard();
        int idx, w;
        bit ok;
        do_reset();
        cfg_guard_i = 8'd5;
        req_data_i  = '0;
        req_data_i[15:8] = 8'h77;
        req_valid_i = 4'b0010;
        wait_grant(5, idx, w);
        wait_busy_fall(40, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL guard_busy1: got busy=%b expected fall", tx_busy_i);
        end
        tick();
        cfg_guard_i = 8'd0;
        wait_grant(20, idx, w);
        checks++;
        if (idx != 1 || w + 1 != 6) begin
            errors++; $display("FAIL guard_gap5: got idx=%0d gap=%0d expected 1/6", idx, w + 1);
        end
        wait_busy_fall(40, ok);
        wait_grant(20, idx, w);
        checks++;
        if (!ok || idx != 1 || w != 1) begin
            errors++; $display("FAIL guard_gap0: got idx=%0d gap=%0d expected 1/1", idx, w);
        end
        tick();
        req_valid_i = '0;
        wait_idle(60, ok);
    endtask

    task automatic test_disable_reset();
        int idx, w, bad, n;
        bit ok;
        do_reset();
        model_ready = 1'b0;
        req_data_i  = '0;
        req_data_i[15:8] = 8'h3C;
        req_valid_i = 4'b0010;
        wait_grant(5, idx, w);
        checks++;
        if (idx != 1) begin
            errors++; $display("FAIL dis_grant: got %0d expected 1", idx);
        end
        tick();
        cfg_en_i    = 1'b0;
        req_valid_i = '0;
        bad = 0;
        repeat (4) begin
            tick();
            if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h3C || active_o !== 1'b1 || req_ready_o !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL dis_hold: got %0d bad cycles expected 0", bad);
        end
        cfg_en_i    = 1'b1;
        model_ready = 1'b1;
        n = 0;
        while (tx_busy_i !== 1'b1 && n < 10) begin tick(); n++; end
        tick();
        tick();
        checks++;
        if (active_o !== 1'b1 || tx_busy_i !== 1'b1) begin
            errors++; $display("FAIL dis_drain: got active=%b busy=%b expected 1/1", active_o, tx_busy_i);
        end
        rstn_i = 1'b0;
        #1;
        checks++;
        if (req_ready_o !== '0 || tx_valid_o !== 1'b0 || active_o !== 1'b0) begin
            errors++; $display("FAIL rst_hs: got ready=%b valid=%b active=%b expected 0000/0/0", req_ready_o, tx_valid_o, active_o);
        end
        checks++;
        if (tx_data_o !== 8'h00 || grant_id_o !== 2'd0) begin
            errors++; $display("FAIL rst_data: got data=%h grant=%0d expected 00/0", tx_data_o, grant_id_o);
        end
        tick();
        rstn_i      = 1'b1;
        req_data_i  = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
        req_valid_i = 4'b1110;
        wait_grant(5, idx, w);
        checks++;
        if (idx != 1) begin
            errors++; $display("FAIL rst_rr_ptr: got winner %0d expected 1", idx);
        end
        tick();
        req_valid_i = '0;
        checks++;
        if (grant_id_o !== 2'd1 || tx_data_o !== 8'hE1) begin
            errors++; $display("FAIL rst_regrant: got id=%0d data=%h expected 1/e1", grant_id_o, tx_data_o);
        end
        wait_idle(80, ok);
    endtask

    initial begin
        rstn_i       = 1'b0;
        cfg_en_i     = 1'b1;
        cfg_prio_i   = 1'b0;
        cfg_cts_en_i = 1'b0;
        cfg_guard_i  = '0;
        cts_ni       = 1'b0;
        req_data_i   = '0;
        req_valid_i  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_priority();
        test_cts();
        test_guard();
        test_disable_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udma_uart_tx_sched.md
# udma_uart_tx_sched

Transmit scheduler between the uDMA-side byte sources and the UART transmitter. It arbitrates NUM_REQ byte requesters with round-robin or fixed priority for requester 0, and hands one byte at a time to the transmitter's valid/ready port. It also applies optional CTS hardware flow control and a programmable inter-character guard gap. It sits inside the UART channel between the TX uDMA stream, the flow-control byte injector, and the serializer.

## Interface
- NUM_REQ, 4: number of byte requesters (2..8)
- GUARD_W, 8: width of the guard-gap counter
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- cfg_en_i  in  1  channel enable; gates new arbitration
- cfg_prio_i  in  1  1 = requester 0 has strict priority; 0 = pure round-robin
- cfg_cts_en_i  in  1  enable CTS flow control
- cfg_guard_i  in  GUARD_W  idle clock cycles inserted after each frame (0 = none)
- cts_ni  in  1  clear-to-send pin, active-low, asynchronous
- req_data_i  in  NUM_REQ*8  byte per requester; requester k at [8k+7:8k]
- req_valid_i  in  NUM_REQ  byte available per requester
- req_ready_o  out  NUM_REQ  one-hot accept strobe
- tx_data_o  out  8  byte to transmitter
- tx_valid_o  out  1  byte valid to transmitter
- tx_ready_i  in  1  transmitter idle and accepting
- tx_busy_i  in  1  transmitter serializing a frame
- grant_id_o  out  $clog2(NUM_REQ)  index of requester owning the current byte
- active_o  out  1  scheduler not in IDLE

## Operation
- CTS path: cts_ni goes through a 2-flop synchronizer (reset value 1). cts_ok = !cfg_cts_en_i || !cts_sync.
- eligible = cfg_en_i && cts_ok && |req_valid_i.
- Arbitration is combinational in IDLE:
  - If cfg_prio_i && req_valid_i[0], winner = 0 and rr_ptr is unchanged.
  - Otherwise winner = first valid index at or above rr_ptr, wrapping modulo NUM_REQ. rr_ptr <= winner+1, wrapping to 0 at NUM_REQ.
- Requester handshake: accept when req_valid_i[k] && req_ready_o[k]. Requesters hold data and valid stable until accepted. req_ready_o may depend combinationally on req_valid_i.
- FSM states: IDLE, SEND, START, DRAIN, GUARD.
  - IDLE: if eligible, req_ready_o[winner]=1 for that cycle. Latch req_data_i byte into hold_q and winner into grant_id_o, then go to SEND.
  - SEND: tx_valid_o = cts_ok, tx_data_o = hold_q. On tx_valid_o && tx_ready_i, go to START. cfg_en_i low keeps the state in SEND and keeps the byte. Bytes are never dropped.
  - START: wait for tx_busy_i=1, then go to DRAIN. If tx_busy_i=0 && !cfg_en_i, go to IDLE (transmitter disabled; byte lost in the transmitter, not here).
  - DRAIN: wait for tx_busy_i=0. Then go to GUARD with guard_cnt <= cfg_guard_i if cfg_guard_i != 0, else go to IDLE.
  - GUARD: guard_cnt decrements each cycle. When guard_cnt == 1, go to IDLE. cfg_guard_i changes during GUARD have no effect.
- active_o = (state != IDLE). grant_id_o holds its value until the next grant.
- CTS deasserted mid-frame does not abort the frame. It only blocks the next SEND handshake and the next IDLE grant.

## Timing
- Reset values: state IDLE, rr_ptr 0, hold_q 8'h00, tx_data_o 8'h00, tx_valid_o 0, req_ready_o 0, grant_id_o 0, active_o 0, guard_cnt 0, cts_sync 1.
- Latency from grant to transmitter:
  - Cycle 0: grant in IDLE.
  - Cycle 1: tx_valid_o=1. Handshake in the same cycle if tx_ready_i=1.
  - Cycle 2: START.
  - Cycle 3: DRAIN, given the transmitter raises busy one cycle after accepting.
- Frame gap: the next grant occurs cfg_guard_i+1 cycles after the cycle tx_busy_i falls, or 1 cycle when cfg_guard_i=0.
- CTS latency: 2 cycles from a cts_ni edge to an effect on eligibility.
- Simultaneous events:
  - cfg_prio_i and requester 0 both active: requester 0 wins every eligible IDLE cycle, so other requesters can starve (by design).
  - cfg_en_i falling in the same cycle as a grant: the grant is blocked.
- Asynchronous reset mid-frame returns all state to reset values at once. A byte held in hold_q is discarded.

## Test plan
- Single byte: requester 2 presents 8'hA5, cfg_guard_i=0, transmitter model with tx_ready_i=1 and 10-cycle busy. Expect req_ready_o=4'b0100 at cycle 0, tx_valid_o with 8'hA5 at cycle 1, grant_id_o=2, active_o low 1 cycle after busy falls.
- Round-robin: all 4 requesters valid continuously, cfg_prio_i=0. Expect grant order 0,1,2,3,0,1 with bytes matching each requester's data.
- Priority: cfg_prio_i=1, requesters 0 and 3 valid, requester 0 supplies 3 bytes then drops valid. Expect grants 0,0,0,3. rr_ptr is unaffected by the priority grants, so requester 3 is served next.
- CTS: cfg_cts_en_i=1, cts_ni=1, byte pending. Expect no req_ready_o and tx_valid_o=0. Drive cts_ni=0: expect the grant 2-3 cycles later. Raise cts_ni mid-frame: expect the current frame to complete and the next grant to be blocked.
- Guard gap: cfg_guard_i=5, two back-to-back bytes. Expect exactly 6 cycles from tx_busy_i falling to the second req_ready_o pulse.
- Disable and reset: drop cfg_en_i while in SEND with tx_ready_i=0. Expect the byte held and tx_valid_o kept high. Pulse rstn_i low during DRAIN: expect all outputs at their reset values and rr_ptr=0.
